// File: rtl/fft_fixed_pkg.sv
// Fixed-point helpers shared by the left- and right-shift scalers of the FFT datapath.
// Holds the default word width, the saturation bounds and the rounding mode.
package fft_fixed_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic {
    ROUND_TRUNC,
    ROUND_HALF_UP
  } round_mode_t;

  localparam round_mode_t ROUND_MODE = ROUND_HALF_UP;

  // Bounds come back as 64-bit patterns; callers keep the low `width` bits.
  function automatic logic [63:0] SAT_MAX(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] SAT_MIN(input int width);
    return ~SAT_MAX(width);
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clamp from IN_W to OUT_W bits, flagging when the input
// does not fit and had to be pinned to the nearest bound.
module sat_clamp
  import fft_fixed_pkg::*;
#(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam logic [63:0]      MAX_64 = SAT_MAX(OUT_W);
  localparam logic [63:0]      MIN_64 = SAT_MIN(OUT_W);
  localparam logic [OUT_W-1:0] MAX_W  = MAX_64[OUT_W-1:0];
  localparam logic [OUT_W-1:0] MIN_W  = MIN_64[OUT_W-1:0];

  // The value fits only if every bit from the output sign bit upward agrees.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = din[IN_W-1:OUT_W-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  always_comb begin
    dout = din[OUT_W-1:0];
    if (ovf) begin
      dout = din[IN_W-1] ? MIN_W : MAX_W;
    end
  end

endmodule

// File: rtl/rshift_rescaler.sv
// Two-stage elastic rescaler: S1 rounds half-up and arithmetic-shifts right,
// S2 saturates to DATA_WIDTH bits and counts saturation events.
module rshift_rescaler
  import fft_fixed_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int RSHIFT_AMOUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] D_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   D_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf_sticky,
  output logic [7:0]              sat_count,
  input  logic                    ovf_clr
);

  localparam int W_IN   = 2 * DATA_WIDTH;
  localparam int W_T    = W_IN + 1;
  localparam int RND_SH = (RSHIFT_AMOUNT > 0) ? RSHIFT_AMOUNT - 1 : 0;
  localparam logic [W_T-1:0] RND =
    (ROUND_MODE == ROUND_HALF_UP && RSHIFT_AMOUNT > 0) ? (W_T'(1) << RND_SH) : '0;

  logic                  s1_valid;
  logic [W_T-1:0]        s1_data;
  logic                  s1_adv;
  logic                  s2_adv;
  logic signed [W_T-1:0] t_sum;
  logic signed [W_T-1:0] t_shift;
  logic [DATA_WIDTH-1:0] clamp_out;
  logic                  clamp_ovf;
  logic                  sat_event;

  // Handshake: a transfer happens on any cycle where valid and ready are both
  // high; valid never waits on ready, and a stalled stage holds its contents.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // One extra bit keeps the rounding carry out of the sign position.
  assign t_sum   = $signed({D_in[W_IN-1], D_in}) + $signed(RND);
  assign t_shift = t_sum >>> RSHIFT_AMOUNT;

  sat_clamp #(
    .IN_W (W_T),
    .OUT_W(DATA_WIDTH)
  ) u_sat_clamp (
    .din (s1_data),
    .dout(clamp_out),
    .ovf (clamp_ovf)
  );

  assign sat_event = s2_adv && s1_valid && clamp_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      out_valid  <= 1'b0;
      D_out      <= '0;
      ovf_sticky <= 1'b0;
      sat_count  <= 8'd0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= t_shift;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          D_out <= clamp_out;
        end
      end
      // A same-cycle event outranks the clear, restarting the count at one.
      if (sat_event) begin
        ovf_sticky <= 1'b1;
        if (ovf_clr) begin
          sat_count <= 8'd1;
        end else if (sat_count != 8'hFF) begin
          sat_count <= sat_count + 8'd1;
        end
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
        sat_count  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_rshift_rescaler.sv
// Directed bench for rshift_rescaler: arithmetic reference model with a per-cycle
// compare process, plus literal expectations for the documented corner cases.
module tb_rshift_rescaler;

  localparam int DW = 16;
  localparam int RS = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*DW-1:0] d_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] d_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          ovf_sticky;
  logic [7:0]    sat_count;
  logic          ovf_clr = 1'b0;

  always #5 clk = ~clk;

  rshift_rescaler #(
    .DATA_WIDTH   (DW),
    .RSHIFT_AMOUNT(RS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .D_in      (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D_out     (d_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_sticky(ovf_sticky),
    .sat_count (sat_count),
    .ovf_clr   (ovf_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: round half-up, floor divide by 2^RS, clamp. Bit 16 flags saturation.
  function automatic logic [16:0] model(input logic [31:0] x);
    longint v, d, q;
    v = longint'($signed(x));
    d = longint'(1) << RS;
    if (RS > 0) v = v + d / 2;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    if (q > 32767) return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  // scoreboard
  logic [16:0] exp_q[$];
  int          exp_cnt = 0;
  logic        prev_rst = 1'b1;
  logic        prev_clr = 1'b0;
  logic        prev_ov = 1'b0;
  logic        prev_or = 1'b1;
  logic [DW-1:0] prev_dout = '0;
  logic        new_head;
  logic [16:0] head;

  always @(negedge clk) begin
    if (prev_rst) begin
      exp_cnt = 0;
    end else begin
      new_head = out_valid && (!prev_ov || prev_or);
      if (new_head && exp_q.size() > 0 && exp_q[0][16])
        exp_cnt = prev_clr ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
      else if (prev_clr)
        exp_cnt = 0;
    end
    check("sat_count_model", sat_count, exp_cnt);
    check("ovf_sticky_model", ovf_sticky, (exp_cnt != 0));
    if (prev_rst) begin
      check("valid_after_rst", out_valid, 0);
    end else if (prev_ov && !prev_or) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", d_out, prev_dout);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        head = exp_q.pop_front();
        check("d_out_model", d_out, head[15:0]);
      end
    end
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(d_in));
    prev_rst  = rst;
    prev_clr  = ovf_clr;
    prev_ov   = out_valid;
    prev_or   = out_ready;
    prev_dout = d_out;
  end

  // driver tasks
  task automatic send_one(input logic [31:0] data);
    bit ok = 0;
    d_in = data;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [15:0] exp);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
    else check(name, d_out, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_in[4];
  logic [15:0] got[$];
  int          idx;
  int          accepted;

  initial begin
    bp_in[0] = 32'h0000_0100;
    bp_in[1] = 32'h0000_0200;
    bp_in[2] = 32'h0000_0300;
    bp_in[3] = 32'h0000_0400;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_d_out", d_out, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
    step();

    // basic rounding and 2-cycle latency
    send_one(32'h0001_2380);
    @(negedge clk);
    check("lat_cycle1_invalid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_d_out", d_out, 16'h0124);
    check("lat_sticky", ovf_sticky, 0);
    step();

    // half-up on negatives
    send_one(32'hFFFF_FF80);
    wait_out("neg_half_up", 16'h0000);
    step();
    send_one(32'hFFFF_FF7F);
    wait_out("neg_below_half", 16'hFFFF);
    step();

    // rounding carry saturates positive, then negative saturation
    send_one(32'h007F_FF80);
    wait_out("carry_sat", 16'h7FFF);
    check("carry_sat_count", sat_count, 1);
    step();
    send_one(32'h8000_0000);
    wait_out("neg_sat", 16'h8000);
    check("neg_sat_count", sat_count, 2);
    check("neg_sat_sticky", ovf_sticky, 1);
    step();

    // backpressure: out_ready low for 6 cycles while 4 samples are offered
    out_ready = 1'b0;
    idx = 0;
    accepted = 0;
    d_in = bp_in[0];
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        accepted++;
        idx++;
      end
      step();
      d_in = bp_in[idx];
    end
    @(negedge clk);
    check("bp_accepted", accepted, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_held_valid", out_valid, 1);
    check("bp_held_data", d_out, 16'h0001);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && got.size() < 4; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(d_out);
      if (in_valid && in_ready) idx++;
      step();
      if (idx < 4) d_in = bp_in[idx];
      else in_valid = 1'b0;
    end
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check("bp_order", got[i], 16'(i + 1));
    end
    in_valid = 1'b0;
    step();

    // clear coinciding with a saturation event, then a clear alone
    send_one(32'h7FFF_FFFF);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_evt_valid", out_valid, 1);
    check("clr_evt_data", d_out, 16'h7FFF);
    check("clr_evt_sticky", ovf_sticky, 1);
    check("clr_evt_count", sat_count, 1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_alone_sticky", ovf_sticky, 0);
    check("clr_alone_count", sat_count, 0);
    step();

    // reset with both stages full
    out_ready = 1'b0;
    send_one(32'h8000_0000);
    send_one(32'h0000_0500);
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    check("full_sat_count", sat_count, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", sat_count, 0);
    check("mid_rst_sticky", ovf_sticky, 0);
    out_ready = 1'b1;
    step();
    send_one(32'h0000_0600);
    @(negedge clk);
    check("post_rst_lat1", out_valid, 0);
    @(negedge clk);
    check("post_rst_lat2", out_valid, 1);
    check("post_rst_data", d_out, 16'h0006);
    step();

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rshift_rescaler.md
RSHIFT_RESCALER -- requirements
Module: rshift_rescaler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the narrow output word; the input word is 2*DATA_WIDTH.
REQ-002 SHALL have parameter RSHIFT_AMOUNT, default 8: arithmetic right-shift applied to the input; legal range 0..DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port D_in  input  2*DATA_WIDTH  signed two's-complement wide sample.
REQ-006 SHALL have port in_valid  input  1  D_in is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts D_in this cycle.
REQ-008 SHALL have port D_out  output  DATA_WIDTH  signed rescaled, rounded, saturated sample.
REQ-009 SHALL have port out_valid  output  1  D_out is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts D_out.
REQ-011 SHALL have port ovf_sticky  output  1  at least one saturation has occurred since the last clear.
REQ-012 SHALL have port sat_count  output  8  number of saturation events since the last clear; holds at 255.
REQ-013 SHALL have port ovf_clr  input  1  clears ovf_sticky and sat_count.

Function
REQ-014 SHALL complete a transfer on any cycle where valid and ready are both high, on each side independently.
REQ-015 SHALL implement a 2-stage elastic pipeline: S1 rounds and shifts, S2 saturates and drives D_out/out_valid.
REQ-016 SHALL give latency of exactly 2 cycles from input transfer to out_valid when out_ready is held high, at a throughput of 1 sample per cycle.
REQ-017 SHALL advance S2 when S2 is empty or out_ready=1; SHALL advance S1 when S1 is empty or S2 advances.
REQ-018 SHALL drive in_ready = (S1 empty) OR (S1 advances); a combinational path from out_ready to in_ready is permitted.
REQ-019 SHALL hold D_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL never drop, duplicate or reorder samples under any backpressure pattern.
REQ-021 SHALL round half-up when RSHIFT_AMOUNT>0: t = D_in + 2^(RSHIFT_AMOUNT-1), then arithmetic right shift by RSHIFT_AMOUNT.
REQ-022 SHALL compute t at 2*DATA_WIDTH+1 bits so the rounding carry is never lost.
REQ-023 SHALL apply no rounding when RSHIFT_AMOUNT=0.
REQ-024 SHALL saturate the shifted value to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; D_out is the low DATA_WIDTH bits when in range.
REQ-025 SHALL count a saturation event at the cycle the saturated sample enters S2.
REQ-026 SHALL set ovf_sticky and increment sat_count (saturating at 255) on each saturation event.
REQ-027 SHALL, when ovf_clr and a saturation event occur in the same cycle, end with ovf_sticky=1 and sat_count=1 (the set wins over the clear).
REQ-028 SHALL, when ovf_clr occurs without an event, end with ovf_sticky=0 and sat_count=0 on the next cycle.

Reset
REQ-029 SHALL on rst=1 clear both stage-valid flags: out_valid=0, D_out=0, ovf_sticky=0, sat_count=0.
REQ-030 SHALL drive in_ready=1 from the first cycle after reset release.
REQ-031 SHALL discard in-flight samples when rst is asserted mid-stream; no partial output appears after reset.
REQ-032 SHALL give rst priority over ovf_clr and over all handshakes.

Structure
REQ-033 SHALL take the DATA_WIDTH default, the SAT_MAX/SAT_MIN constant functions and the rounding-mode constant from the shared package fft_fixed_pkg, which is shared with the left-shift scaler.
REQ-034 SHALL place the clamp and overflow detection in one sub-module, sat_clamp (combinational, parameterised by the input and output widths), instantiated in S2.

Verification (DATA_WIDTH=16, RSHIFT_AMOUNT=8, out_ready=1 unless stated)
REQ-035 SHALL cover: D_in=0x00012380 -> D_out=0x0124 exactly 2 cycles later, ovf_sticky stays 0.
REQ-036 SHALL cover: D_in=0xFFFFFF80 -> 0x0000; D_in=0xFFFFFF7F -> 0xFFFF (half-up on negatives).
REQ-037 SHALL cover: D_in=0x007FFF80 (rounding carry) -> 0x7FFF with sat_count=1; then D_in=0x80000000 -> 0x8000 with sat_count=2 and ovf_sticky=1.
REQ-038 SHALL cover: out_ready=0 for 6 cycles while 4 samples are offered -> exactly 2 accepted, in_ready=0 thereafter, D_out held; on release, all samples emerge in order with none lost.
REQ-039 SHALL cover: ovf_clr pulsed in the same cycle as a saturating sample reaches S2 -> ovf_sticky=1, sat_count=1; a second ovf_clr alone -> both 0.
REQ-040 SHALL cover: rst pulsed with both stages full -> out_valid=0 the next cycle, the following input appears 2 cycles after acceptance, and sat_count=0.
